// File: rtl/led_pkg.sv
// Shared types and helpers for the TLC5955 bus sequencer.
package led_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT_START,
      S_INIT_WAIT,
      S_GS_START,
      S_GS_WAIT,
      S_SLOT_WAIT
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_INIT,
      OWN_GS
   } owner_e;

   localparam int OVR_W = 8;

   function automatic int layer_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_bus_mux.sv
// Steers one writer onto the shared LAT/SCLK/SDO bus by owner.
module led_bus_mux
   import led_pkg::*;
#(
   parameter int NUM_SHIFT = 4
) (
   input  logic [1:0]           owner_i,
   input  logic                 init_lat_i,
   input  logic                 init_sclk_i,
   input  logic                 init_sdo_i,
   input  logic                 gs_lat_i,
   input  logic                 gs_sclk_i,
   input  logic [NUM_SHIFT-1:0] gs_sdos_i,
   output logic                 lat_o,
   output logic                 sclk_o,
   output logic [NUM_SHIFT-1:0] sdos_o
);

   always_comb begin
      lat_o  = 1'b0;
      sclk_o = 1'b0;
      sdos_o = '0;
      unique case (owner_e'(owner_i))
         OWN_INIT: begin
            lat_o  = init_lat_i;
            sclk_o = init_sclk_i;
            sdos_o = {NUM_SHIFT{init_sdo_i}};
         end
         OWN_GS: begin
            lat_o  = gs_lat_i;
            sclk_o = gs_sclk_i;
            sdos_o = gs_sdos_i;
         end
         default: begin
            lat_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/led_bus_sequencer.sv
// Owns the TLC5955 shift bus and schedules the init and
// grayscale writers into fixed-period layer slots.
module led_bus_sequencer
   import led_pkg::*;
#(
   parameter int NUM_SHIFT     = 4,
   parameter int NUM_LAYERS    = 8,
   parameter int LAYER_PERIOD  = 4096,
   parameter int TIMEOUT       = 65535,
   parameter int REINIT_FRAMES = 64
) (
   input  logic                              spiClk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              reinitReq,
   output logic                              initStart,
   input  logic                              initDone,
   input  logic                              initLat,
   input  logic                              initSclk,
   input  logic                              initSdo,
   output logic                              gsStart,
   input  logic                              gsDone,
   input  logic                              gsLat,
   input  logic                              gsSclk,
   input  logic [NUM_SHIFT-1:0]              gsSdos,
   output logic                              LAT,
   output logic                              SCLK,
   output logic [NUM_SHIFT-1:0]              SDOs,
   output logic [layer_w(NUM_LAYERS)-1:0]    layerSel,
   output logic                              layerAdvance,
   output logic                              blank,
   output logic                              fault,
   output logic [OVR_W-1:0]                  overrunCnt
);

   localparam int LW = layer_w(NUM_LAYERS);
   localparam int SW = $clog2(LAYER_PERIOD);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = (REINIT_FRAMES > 0) ?
                       $clog2(REINIT_FRAMES + 1) : 1;

   localparam logic [SW-1:0] SLOT_LAST  = SW'(LAYER_PERIOD - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);
   localparam logic [FW-1:0] FRAME_LIM  = FW'(REINIT_FRAMES);

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic [SW-1:0]    slot_q, slot_d;
   logic [TW-1:0]    to_q, to_d;
   logic [LW-1:0]    layer_q, layer_d;
   logic [FW-1:0]    frame_q, frame_d;
   logic             blank_q, blank_d;
   logic             fault_q, fault_d;
   logic             ovr_q, ovr_d;
   logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
   logic             adv_q, adv_d;
   logic             reinit_q, reinit_d;

   logic             boundary;
   logic             to_exp;
   logic             in_run;
   logic             wrap;
   logic [LW-1:0]    layer_nxt;
   logic [FW-1:0]    frame_nxt;
   logic             reinit_due;
   logic             do_adv;
   logic             do_sched;

   assign boundary  = (slot_q == SLOT_LAST);
   assign to_exp    = (to_q == TO_LAST);
   assign in_run    = (state_q == S_GS_START) ||
                      (state_q == S_GS_WAIT)  ||
                      (state_q == S_SLOT_WAIT);
   assign wrap      = (layer_q == LAYER_LAST);
   assign layer_nxt = wrap ? '0 : layer_q + LW'(1);
   assign frame_nxt = wrap ? frame_q + FW'(1) : frame_q;
   assign reinit_due = reinit_q ||
                       ((REINIT_FRAMES != 0) &&
                        (frame_nxt == FRAME_LIM));

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      slot_d    = slot_q;
      to_d      = to_q;
      layer_d   = layer_q;
      frame_d   = frame_q;
      blank_d   = blank_q;
      fault_d   = fault_q;
      ovr_d     = ovr_q;
      ovr_cnt_d = ovr_cnt_q;
      adv_d     = 1'b0;
      reinit_d  = reinit_q | reinitReq;
      do_adv    = 1'b0;
      do_sched  = 1'b0;

      if (in_run) begin
         slot_d = boundary ? '0 : slot_q + SW'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            blank_d  = 1'b1;
            owner_d  = OWN_NONE;
            reinit_d = 1'b0;
            if (enable) state_d = S_INIT_START;
         end
         S_INIT_START: begin
            owner_d  = OWN_INIT;
            to_d     = '0;
            reinit_d = 1'b0;
            state_d  = S_INIT_WAIT;
         end
         S_INIT_WAIT: begin
            reinit_d = 1'b0;
            to_d     = to_q + TW'(1);
            if (initDone) begin
               slot_d  = '0;
               blank_d = 1'b0;
               state_d = S_GS_START;
            end else if (to_exp) begin
               fault_d = 1'b1;
               state_d = S_INIT_START;
            end
         end
         S_GS_START: begin
            owner_d = OWN_GS;
            to_d    = '0;
            ovr_d   = 1'b0;
            state_d = S_GS_WAIT;
         end
         S_GS_WAIT: begin
            to_d = to_q + TW'(1);
            if (gsDone && ovr_q) begin
               do_adv  = 1'b1;
               slot_d  = '0;
               state_d = S_GS_START;
            end else if (gsDone) begin
               // Done on the boundary cycle still counts as on time.
               if (boundary) begin
                  do_adv   = 1'b1;
                  do_sched = 1'b1;
               end else begin
                  state_d = S_SLOT_WAIT;
               end
            end else if (to_exp) begin
               fault_d = 1'b1;
               blank_d = 1'b1;
               state_d = S_INIT_START;
            end else if (boundary && !ovr_q) begin
               ovr_d = 1'b1;
               if (ovr_cnt_q != '1) begin
                  ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
               end
            end
         end
         S_SLOT_WAIT: begin
            if (boundary) begin
               do_adv   = 1'b1;
               do_sched = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (do_adv) begin
         adv_d   = 1'b1;
         layer_d = layer_nxt;
         frame_d = frame_nxt;
      end

      if (do_sched) begin
         if (!enable) begin
            state_d = S_IDLE;
            blank_d = 1'b1;
            owner_d = OWN_NONE;
         end else if (reinit_due) begin
            state_d  = S_INIT_START;
            blank_d  = 1'b1;
            reinit_d = 1'b0;
            frame_d  = '0;
         end else begin
            state_d = S_GS_START;
         end
      end
   end

   always_ff @(posedge spiClk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_NONE;
         slot_q    <= '0;
         to_q      <= '0;
         layer_q   <= '0;
         frame_q   <= '0;
         blank_q   <= 1'b1;
         fault_q   <= 1'b0;
         ovr_q     <= 1'b0;
         ovr_cnt_q <= '0;
         adv_q     <= 1'b0;
         reinit_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         slot_q    <= slot_d;
         to_q      <= to_d;
         layer_q   <= layer_d;
         frame_q   <= frame_d;
         blank_q   <= blank_d;
         fault_q   <= fault_d;
         ovr_q     <= ovr_d;
         ovr_cnt_q <= ovr_cnt_d;
         adv_q     <= adv_d;
         reinit_q  <= reinit_d;
      end
   end

   assign initStart    = (state_q == S_INIT_START);
   assign gsStart      = (state_q == S_GS_START);
   assign layerSel     = layer_q;
   assign layerAdvance = adv_q;
   assign blank        = blank_q;
   assign fault        = fault_q;
   assign overrunCnt   = ovr_cnt_q;

   led_bus_mux #(
      .NUM_SHIFT (NUM_SHIFT)
   ) u_mux (
      .owner_i     (owner_q),
      .init_lat_i  (initLat),
      .init_sclk_i (initSclk),
      .init_sdo_i  (initSdo),
      .gs_lat_i    (gsLat),
      .gs_sclk_i   (gsSclk),
      .gs_sdos_i   (gsSdos),
      .lat_o       (LAT),
      .sclk_o      (SCLK),
      .sdos_o      (SDOs)
   );

endmodule

// File: tb/tb_led_bus_sequencer.sv
// Directed bench for led_bus_sequencer with simple writer models.
module tb_led_bus_sequencer;

   logic       spiClk;
   logic       reset;
   logic       enable;
   logic       reinitReq;
   logic       initStart;
   logic       initDone;
   logic       initLat;
   logic       initSclk;
   logic       initSdo;
   logic       gsStart;
   logic       gsDone;
   logic       gsLat;
   logic       gsSclk;
   logic [3:0] gsSdos;
   logic       LAT;
   logic       SCLK;
   logic [3:0] SDOs;
   logic [2:0] layerSel;
   logic       layerAdvance;
   logic       blank;
   logic       fault;
   logic [7:0] overrunCnt;

   int checks = 0;
   int errors = 0;
   int init_starts = 0;
   int init_delay = 100;
   int gs_delay = 50;
   logic init_hang = 1'b0;
   int init_cnt = 0;
   logic init_busy = 1'b0;
   int gs_cnt = 0;
   logic gs_busy = 1'b0;

   localparam int SIG_INIT = 0;
   localparam int SIG_GS   = 1;
   localparam int SIG_ADV  = 2;
   localparam int SIG_FLT  = 3;
   localparam int SIG_IDN  = 4;

   led_bus_sequencer #(
      .NUM_SHIFT     (4),
      .NUM_LAYERS    (8),
      .LAYER_PERIOD  (256),
      .TIMEOUT       (1000),
      .REINIT_FRAMES (2)
   ) dut (
      .spiClk       (spiClk),
      .reset        (reset),
      .enable       (enable),
      .reinitReq    (reinitReq),
      .initStart    (initStart),
      .initDone     (initDone),
      .initLat      (initLat),
      .initSclk     (initSclk),
      .initSdo      (initSdo),
      .gsStart      (gsStart),
      .gsDone       (gsDone),
      .gsLat        (gsLat),
      .gsSclk       (gsSclk),
      .gsSdos       (gsSdos),
      .LAT          (LAT),
      .SCLK         (SCLK),
      .SDOs         (SDOs),
      .layerSel     (layerSel),
      .layerAdvance (layerAdvance),
      .blank        (blank),
      .fault        (fault),
      .overrunCnt   (overrunCnt)
   );

   initial spiClk = 1'b0;
   always #5 spiClk = ~spiClk;

   always @(posedge spiClk) begin
      if (initStart) init_starts <= init_starts + 1;
   end

   always @(posedge spiClk) begin
      initDone <= 1'b0;
      if (reset) begin
         init_busy <= 1'b0;
      end else if (initStart) begin
         init_busy <= 1'b1;
         init_cnt  <= 1;
      end else if (init_busy) begin
         if (init_cnt == init_delay && !init_hang) begin
            initDone  <= 1'b1;
            init_busy <= 1'b0;
         end else begin
            init_cnt <= init_cnt + 1;
         end
      end
   end

   always @(posedge spiClk) begin
      gsDone <= 1'b0;
      if (reset) begin
         gs_busy <= 1'b0;
      end else if (gsStart) begin
         gs_busy <= 1'b1;
         gs_cnt  <= 1;
      end else if (gs_busy) begin
         if (gs_cnt == gs_delay) begin
            gsDone  <= 1'b1;
            gs_busy <= 1'b0;
         end else begin
            gs_cnt <= gs_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig_of(input int which);
      case (which)
         SIG_INIT: return initStart;
         SIG_GS:   return gsStart;
         SIG_ADV:  return layerAdvance;
         SIG_FLT:  return fault;
         default:  return initDone;
      endcase
   endfunction

   task automatic wait_sig(input int which, input int maxc,
                           output int n);
      n = 0;
      do begin
         @(negedge spiClk);
         n++;
      end while (!sig_of(which) && n < maxc);
   endtask

   initial begin
      int n;
      int base;
      reset     = 1'b1;
      enable    = 1'b0;
      reinitReq = 1'b0;
      initLat   = 1'b1;
      initSclk  = 1'b0;
      initSdo   = 1'b1;
      gsLat     = 1'b1;
      gsSclk    = 1'b1;
      gsSdos    = 4'b1010;
      repeat (3) @(negedge spiClk);

      chk("rst_blank", blank, 1);
      chk("rst_fault", fault, 0);
      chk("rst_layer", layerSel, 0);
      chk("rst_ovr", overrunCnt, 0);
      chk("rst_lat", LAT, 0);
      chk("rst_sclk", SCLK, 0);
      chk("rst_sdos", SDOs, 0);
      chk("rst_istart", initStart, 0);
      chk("rst_gstart", gsStart, 0);
      chk("rst_adv", layerAdvance, 0);

      reset  = 1'b0;
      enable = 1'b1;
      wait_sig(SIG_INIT, 10, n);
      chk("init_start_lat", n, 1);
      chk("bus_none_lat", LAT, 0);
      @(negedge spiClk);
      chk("bus_init_lat", LAT, 1);
      chk("bus_init_sclk", SCLK, 0);
      chk("bus_init_sdos", SDOs, 4'hF);
      chk("init_blank", blank, 1);

      wait_sig(SIG_IDN, 300, n);
      chk("idone_seen", initDone, 1);
      chk("gs_not_yet", gsStart, 0);
      @(negedge spiClk);
      chk("gs_after_idone", gsStart, 1);
      chk("blank_fell", blank, 0);
      chk("one_init", init_starts, 1);
      @(negedge spiClk);
      chk("bus_gs_lat", LAT, 1);
      chk("bus_gs_sclk", SCLK, 1);
      chk("bus_gs_sdos", SDOs, 4'b1010);

      wait_sig(SIG_ADV, 400, n);
      chk("adv1_time", n, 255);
      chk("adv1_layer", layerSel, 1);
      for (int i = 2; i <= 8; i++) begin
         wait_sig(SIG_ADV, 400, n);
         chk("adv_period", n, 256);
         chk("adv_layer", layerSel, i % 8);
         chk("adv_gs_next", gsStart, 1);
      end
      chk("no_ovr", overrunCnt, 0);

      gs_delay = 300;
      wait_sig(SIG_ADV, 600, n);
      chk("ovr_adv_time", n, 302);
      chk("ovr_cnt", overrunCnt, 1);
      chk("ovr_layer", layerSel, 1);
      chk("ovr_gs_next", gsStart, 1);
      gs_delay = 50;
      for (int i = 10; i <= 15; i++) begin
         wait_sig(SIG_ADV, 400, n);
         chk("post_ovr_period", n, 256);
         chk("post_ovr_layer", layerSel, i % 8);
      end

      wait_sig(SIG_ADV, 400, n);
      chk("adv16_period", n, 256);
      chk("frame_layer", layerSel, 0);
      chk("frame_reinit", initStart, 1);
      chk("frame_blank", blank, 1);
      @(negedge spiClk);
      chk("reinit_sdos", SDOs, 4'hF);
      chk("reinit_lat", LAT, 1);
      initSdo = 1'b0;
      #1;
      chk("reinit_sdo0", SDOs, 4'h0);
      initSdo = 1'b1;
      wait_sig(SIG_IDN, 300, n);
      chk("reinit_hold", layerSel, 0);
      @(negedge spiClk);
      chk("reinit_gs", gsStart, 1);
      chk("init_count2", init_starts, 2);

      reinitReq = 1'b1;
      @(negedge spiClk);
      reinitReq = 1'b0;
      wait_sig(SIG_ADV, 400, n);
      chk("req_adv_time", n, 255);
      chk("req_layer", layerSel, 1);
      chk("req_init", initStart, 1);
      chk("req_blank", blank, 1);
      wait_sig(SIG_IDN, 300, n);
      chk("req_hold", layerSel, 1);
      @(negedge spiClk);
      chk("req_gs", gsStart, 1);

      init_hang = 1'b1;
      reinitReq = 1'b1;
      @(negedge spiClk);
      reinitReq = 1'b0;
      wait_sig(SIG_ADV, 400, n);
      chk("to_adv_layer", layerSel, 2);
      chk("to_init", initStart, 1);
      wait_sig(SIG_FLT, 1200, n);
      chk("to_fault_time", n, 1001);
      chk("to_fault", fault, 1);
      chk("to_restart", initStart, 1);
      chk("to_blank", blank, 1);
      init_hang = 1'b0;
      wait_sig(SIG_IDN, 300, n);
      @(negedge spiClk);
      chk("to_gs", gsStart, 1);
      chk("fault_sticky", fault, 1);
      chk("to_unblank", blank, 0);

      repeat (10) @(negedge spiClk);
      chk("mid_lat", LAT, 1);
      chk("mid_sdos", SDOs, 4'b1010);
      reset = 1'b1;
      @(negedge spiClk);
      chk("mrst_lat", LAT, 0);
      chk("mrst_sclk", SCLK, 0);
      chk("mrst_sdos", SDOs, 0);
      chk("mrst_blank", blank, 1);
      chk("mrst_layer", layerSel, 0);
      chk("mrst_fault", fault, 0);
      chk("mrst_ovr", overrunCnt, 0);
      chk("mrst_gs", gsStart, 0);
      enable = 1'b0;
      @(negedge spiClk);
      reset = 1'b0;
      base = init_starts;
      repeat (20) @(negedge spiClk);
      chk("idle_parked", init_starts, base);
      chk("idle_blank", blank, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
